multicycle_control: RTL and testbench



---
 rtl/riscv_ctrl_pkg.sv | 60 ++++++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_control.sv | 165 ++++++++++++++++
 tb/tb_multicycle_control.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes, datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_XOR = 3'b100;
  localparam logic [2:0] ULA_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decode to ALU operation; flags encodings the ALU does not implement.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [2:0] o_ula_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ula_ctrl = ULA_ADD;
    o_illegal  = 1'b0;
    if (i_funct7 == F7_BASE) begin
      case (i_funct3)
        F3_ADD:  o_ula_ctrl = ULA_ADD;
        F3_AND:  o_ula_ctrl = ULA_AND;
        F3_OR:   o_ula_ctrl = ULA_OR;
        F3_XOR:  o_ula_ctrl = ULA_XOR;
        F3_SLT:  o_ula_ctrl = ULA_SLT;
        default: o_illegal  = 1'b1;
      endcase
    end else if ((i_funct7 == F7_ALT) && (i_funct3 == F3_ADD)) begin
      o_ula_ctrl = ULA_SUB;
    end else begin
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencing FSM; memory states hold until mem_ready.
// Write strobes and the request are gated by reset so nothing leaks while it is held.
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ULAControl,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       illegal_instr
);

  state_t     r_state;
  logic [2:0] w_dec_ula;
  logic       w_dec_illegal;

  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_write;
  logic       w_illegal;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [2:0] w_ula;
  logic [1:0] w_res_src;
  logic [1:0] w_imm_src;

  alu_decoder u_alu_decoder (
    .i_funct3   (Funct3),
    .i_funct7   (Funct7),
    .o_ula_ctrl (w_dec_ula),
    .o_illegal  (w_dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:    if (mem_ready) r_state <= DECODE;
        DECODE: begin
          case (Op)
            OP_LOAD, OP_STORE: r_state <= MEMADR;
            OP_RTYPE:          r_state <= EXECUTER;
            OP_ITYPE:          r_state <= EXECUTEI;
            OP_BRANCH:         r_state <= BEQ;
            default:           r_state <= FETCH;
          endcase
        end
        MEMADR:   r_state <= (Op == OP_STORE) ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ready) r_state <= MEMWB;
        MEMWB:    r_state <= FETCH;
        MEMWRITE: if (mem_ready) r_state <= FETCH;
        EXECUTER: r_state <= w_dec_illegal ? FETCH : ALUWB;
        EXECUTEI: r_state <= (Funct3 == F3_ADD) ? ALUWB : FETCH;
        ALUWB:    r_state <= FETCH;
        BEQ:      r_state <= FETCH;
        default:  r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_adr_src   = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    w_src_a     = SRCA_PC;
    w_src_b     = SRCB_RS2;
    w_ula       = ULA_ADD;
    w_res_src   = RES_ALUOUT;
    w_imm_src   = IMM_I;
    case (r_state)
      FETCH: begin
        // PC+4 goes straight from the ALU so the PC update lands with the IR latch
        w_mem_req  = 1'b1;
        w_src_b    = SRCB_FOUR;
        w_res_src  = RES_ALURESULT;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      DECODE: begin
        w_src_a   = SRCA_OLDPC;
        w_src_b   = SRCB_IMM;
        w_imm_src = IMM_B;
        w_illegal = ~op_supported(Op);
      end
      MEMADR: begin
        w_src_a   = SRCA_RS1;
        w_src_b   = SRCB_IMM;
        w_imm_src = (Op == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      MEMWB: begin
        w_res_src   = RES_MEMDATA;
        w_reg_write = 1'b1;
      end
      MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
      end
      EXECUTER: begin
        w_src_a   = SRCA_RS1;
        w_src_b   = SRCB_RS2;
        w_ula     = w_dec_ula;
        w_illegal = w_dec_illegal;
      end
      EXECUTEI: begin
        w_src_a   = SRCA_RS1;
        w_src_b   = SRCB_IMM;
        w_imm_src = IMM_I;
        w_illegal = (Funct3 != F3_ADD);
      end
      ALUWB: begin
        w_res_src   = RES_ALUOUT;
        w_reg_write = 1'b1;
      end
      BEQ: begin
        w_src_a    = SRCA_RS1;
        w_src_b    = SRCB_RS2;
        w_ula      = ULA_SUB;
        w_res_src  = RES_ALUOUT;
        w_pc_write = Zero;
      end
      default: ;
    endcase
  end

  assign mem_req       = w_mem_req   & ~reset;
  assign MemWrite      = w_mem_write & ~reset;
  assign IRWrite       = w_ir_write  & ~reset;
  assign PCWrite       = w_pc_write  & ~reset;
  assign RegWrite      = w_reg_write & ~reset;
  assign illegal_instr = w_illegal   & ~reset;
  assign AdrSrc        = w_adr_src;
  assign ALUSrcA       = w_src_a;
  assign ALUSrcB       = w_src_b;
  assign ULAControl    = w_ula;
  assign ResultSrc     = w_res_src;
  assign ImmSrc        = w_imm_src;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle traces built from the
// instruction's phase list, compared every cycle against all controller outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal_instr;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ULAControl;

  int total = 0;
  int bad   = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct3(Funct3), .Funct7(Funct7),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ULAControl(ULAControl),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] src_a, src_b;
    logic [2:0] ula;
    logic [1:0] res, imm;
  } cyc_t;

  cyc_t q[$];

  function automatic cyc_t blank();
    cyc_t c;
    c = '0;
    c.rdy = 1'($urandom_range(0, 1));
    return c;
  endfunction

  function automatic void ref_alu(input logic [6:0] f7, input logic [2:0] f3,
                                  output logic ok, output logic [2:0] ula);
    logic [12:0] tab [6];
    tab = '{ {7'h00, 3'd0, 3'd0}, {7'h20, 3'd0, 3'd1}, {7'h00, 3'd7, 3'd2},
             {7'h00, 3'd6, 3'd3}, {7'h00, 3'd4, 3'd4}, {7'h00, 3'd2, 3'd5} };
    ok  = 1'b0;
    ula = 3'd0;
    for (int k = 0; k < 6; k++)
      if (tab[k][12:3] == {f7, f3}) begin
        ok  = 1'b1;
        ula = tab[k][2:0];
      end
  endfunction

  // One memory access phase: wait cycles with ready low, then the completing cycle.
  task automatic push_mem(input int waits, input logic wr);
    cyc_t c;
    for (int w = 0; w <= waits; w++) begin
      c = '0;
      c.rdy = (w == waits);
      c.mem_req = 1'b1;
      c.adr_src = 1'b1;
      c.mem_write = wr;
      q.push_back(c);
    end
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic zero, input int wf, input int wm);
    cyc_t c;
    logic ok;
    logic [2:0] ula;
    for (int w = 0; w <= wf; w++) begin
      c = '0;
      c.rdy = (w == wf);
      c.mem_req = 1'b1;
      c.src_b = 2'b10;
      c.res = 2'b10;
      c.ir_write = c.rdy;
      c.pc_write = c.rdy;
      q.push_back(c);
    end
    c = blank();
    c.src_a = 2'b01; c.src_b = 2'b01; c.imm = 2'b10;
    if (!(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011})) begin
      c.illegal = 1'b1;
      q.push_back(c);
      return;
    end
    q.push_back(c);
    c = blank();
    case (op)
      7'b0000011, 7'b0100011: begin
        c.src_a = 2'b10; c.src_b = 2'b01;
        c.imm = (op == 7'b0100011) ? 2'b01 : 2'b00;
        q.push_back(c);
        if (op == 7'b0100011) push_mem(wm, 1'b1);
        else begin
          push_mem(wm, 1'b0);
          c = blank();
          c.res = 2'b01; c.reg_write = 1'b1;
          q.push_back(c);
        end
      end
      7'b0110011, 7'b0010011: begin
        c.src_a = 2'b10;
        if (op == 7'b0110011) begin
          ref_alu(f7, f3, ok, ula);
          c.src_b = 2'b00; c.ula = ula;
        end else begin
          ok = (f3 == 3'd0);
          c.src_b = 2'b01;
        end
        c.illegal = ~ok;
        q.push_back(c);
        if (ok) begin
          c = blank();
          c.reg_write = 1'b1;
          q.push_back(c);
        end
      end
      default: begin
        c.src_a = 2'b10; c.ula = 3'b001; c.pc_write = zero;
        q.push_back(c);
      end
    endcase
  endtask

  task automatic run_trace(input string name, input int n);
    cyc_t e;
    logic [17:0] got, want;
    for (int i = 0; i < n; i++) begin
      e = q[i];
      mem_ready = e.rdy;
      @(negedge clk);
      got  = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal_instr,
              ALUSrcA, ALUSrcB, ULAControl, ResultSrc, ImmSrc};
      want = e[17:0];
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s cyc %0d: got %05h want %05h", name, i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic zero, input int wf, input int wm);
    Op = op; Funct3 = f3; Funct7 = f7; Zero = zero;
    q.delete();
    build(op, f3, f7, zero, wf, wm);
    run_trace(name, q.size());
  endtask

  task automatic check_strobes_off(input string name);
    logic [5:0] s;
    s = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal_instr};
    total++;
    if (s !== 6'b0) begin
      bad++;
      $display("FAIL %s: strobes got %b want 000000", name, s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; Op = 7'b0110011; Funct3 = 3'd0; Funct7 = 7'd0; Zero = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_strobes_off("reset_hold");
      @(posedge clk);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_add();
    run_instr("add", 7'b0110011, 3'd0, 7'h00, 1'b0, 0, 0);
  endtask

  task automatic test_lb_waits();
    run_instr("lb_wait3", 7'b0000011, 3'd0, 7'h00, 1'b0, 0, 3);
  endtask

  task automatic test_sb();
    run_instr("sb", 7'b0100011, 3'd2, 7'h00, 1'b0, 0, 0);
    run_instr("sb_wait", 7'b0100011, 3'd2, 7'h00, 1'b1, 2, 2);
  endtask

  task automatic test_beq();
    run_instr("beq_z1", 7'b1100011, 3'd0, 7'h00, 1'b1, 0, 0);
    run_instr("beq_z0", 7'b1100011, 3'd0, 7'h00, 1'b0, 1, 0);
  endtask

  task automatic test_illegal();
    run_instr("bad_op", 7'b1111111, 3'd0, 7'h00, 1'b0, 0, 0);
    run_instr("bad_rtype", 7'b0110011, 3'd7, 7'h20, 1'b0, 0, 0);
    run_instr("bad_addi", 7'b0010011, 3'd1, 7'h00, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_memread();
    Op = 7'b0000011; Funct3 = 3'd0; Funct7 = 7'd0; Zero = 1'b0;
    q.delete();
    build(7'b0000011, 3'd0, 7'd0, 1'b0, 1, 5);
    run_trace("lb_pre_reset", 5);
    mem_ready = 1'b1;
    #2 reset = 1'b1;
    #1 check_strobes_off("reset_async");
    @(negedge clk);
    check_strobes_off("reset_mid");
    @(posedge clk);
    #1 check_strobes_off("reset_edge");
    reset = 1'b0;
    run_instr("after_reset", 7'b0010011, 3'd0, 7'h00, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6];
    logic [6:0] op, f7;
    logic [2:0] f3;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 5)];
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (op == 7'b0010011 && $urandom_range(0, 3) != 0) f3 = 3'd0;
      run_instr("random", op, f3, f7, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lb_waits();
    test_sb();
    test_beq();
    test_illegal();
    test_reset_mid_memread();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
